// File: rtl/feature_map_ram.sv
// feature_map_ram: single-clock word store for feature-map samples.
// Samples are zero- or sign-extended to the word width on every write.
// Writes go to an explicit address or to an internal auto-increment pointer
// that fills the array. A full array either wraps or drops further auto writes.
// Reads are registered with one cycle of latency. On a same-address
// read/write collision the read returns the new data (write-first).
module feature_map_ram #(
  parameter int DIN_W    = 8,
  parameter int DOUT_W   = 32,
  parameter int DEPTH    = 256,
  parameter int AW       = 8,
  parameter int SIGN_EXT = 0,
  parameter int WRAP     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr,
  input  logic              wr_auto,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DIN_W-1:0]  data_in,
  input  logic              rd,
  input  logic [AW-1:0]     rd_addr,
  output logic [DOUT_W-1:0] data_out,
  output logic              rd_valid,
  output logic [AW-1:0]     wr_ptr,
  output logic [AW:0]       count,
  output logic              full,
  output logic              ovf
);

  // Storage index width: just enough bits to address DEPTH words.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH-1);

  logic [DOUT_W-1:0] mem [DEPTH];
  logic [DOUT_W-1:0] wdata;
  logic [AW-1:0]     weff;
  logic [IW-1:0]     widx;
  logic [IW-1:0]     ridx;
  logic              wr_exp;
  logic              wr_auto_go;
  logic              wr_en;
  logic              ovf_next;
  logic              rd_in_range;

  // Widen the incoming sample to the stored word width.
  generate
    if (DOUT_W > DIN_W) begin : g_ext
      if (SIGN_EXT != 0) begin : g_sign
        assign wdata = {{(DOUT_W-DIN_W){data_in[DIN_W-1]}}, data_in};
      end else begin : g_zero
        assign wdata = {{(DOUT_W-DIN_W){1'b0}}, data_in};
      end
    end else begin : g_same
      assign wdata = data_in;
    end
  endgenerate

  assign full = (count == DEPTH_C);

  // Write qualification: out-of-range explicit writes are ignored, a clear
  // wins over an auto write, and a full array drops auto writes unless wrapping.
  always_comb begin
    wr_exp      = wr && !wr_auto && ({1'b0, wr_addr} < DEPTH_C);
    wr_auto_go  = wr && wr_auto && !clr && (!full || (WRAP != 0));
    ovf_next    = wr && wr_auto && !clr && full && (WRAP == 0);
    wr_en       = !rst && (wr_exp || wr_auto_go);
    weff        = wr_auto ? wr_ptr : wr_addr;
    widx        = weff[IW-1:0];
    ridx        = rd_addr[IW-1:0];
    rd_in_range = ({1'b0, rd_addr} < DEPTH_C);
  end

  // Memory array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[widx] <= wdata;
    end
  end

  // Registered read port with write-first bypass on address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd;
      if (rd) begin
        if (!rd_in_range) begin
          data_out <= '0;
        end else if (wr_en && (weff == rd_addr)) begin
          data_out <= wdata;
        end else begin
          data_out <= mem[ridx];
        end
      end
    end
  end

  // Auto-write pointer, saturating fill count and overflow pulse.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      ovf <= ovf_next;
      if (wr_auto_go) begin
        wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + AW'(1);
        if (!full) begin
          count <= count + (AW+1)'(1);
        end
      end
    end
  end

endmodule
